// File: rtl/sevseg_avalon_ctrl.sv
// Avalon-MM seven-segment display controller.
// Six digit registers plus a control register drive active-low HEX segments.
// The display path supports hex decode or raw patterns, per-digit blanking,
// a shared blink timer and PWM brightness dimming.
// Bus handshake: a write takes effect at the clock edge where avs_write is high.
// A read is captured at the edge where avs_read is high, and avs_readdata
// holds that value until the next read.
module sevseg_avalon_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_HALF = 25000000,
    parameter int PWM_BITS   = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [3:0]              avs_address,
    input  logic                    avs_write,
    input  logic [31:0]             avs_writedata,
    input  logic                    avs_read,
    output logic [31:0]             avs_readdata,
    output logic [7*NUM_DIGITS-1:0] hex_out
);

    localparam int BW = $clog2(BLINK_HALF);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_HALF - 1);
    localparam logic [3:0]    ADDR_CTRL   = 4'h6;
    localparam logic [3:0]    ADDR_VALUE  = 4'h7;
    localparam logic [3:0]    ADDR_STATUS = 4'h8;

    logic [3:0]          dig_nib   [NUM_DIGITS];
    logic                dig_blank [NUM_DIGITS];
    logic                dig_blink [NUM_DIGITS];
    logic [6:0]          dig_raw   [NUM_DIGITS];
    logic                ctrl_en;
    logic                ctrl_raw;
    logic [PWM_BITS-1:0] ctrl_bright;

    logic [BW-1:0]       blink_cnt;
    logic                blink_phase;
    logic [15:0]         wrap_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_on;

    logic [31:0]             rd_next;
    logic [7*NUM_DIGITS-1:0] hex_next;
    logic [6:0]              src;

    // Several writedata bits have no home in any register; they are dropped here.
    logic unused_wdata;
    assign unused_wdata = ^avs_writedata;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0: seg_decode = 7'h40;
            4'h1: seg_decode = 7'h79;
            4'h2: seg_decode = 7'h24;
            4'h3: seg_decode = 7'h30;
            4'h4: seg_decode = 7'h19;
            4'h5: seg_decode = 7'h12;
            4'h6: seg_decode = 7'h02;
            4'h7: seg_decode = 7'h78;
            4'h8: seg_decode = 7'h00;
            4'h9: seg_decode = 7'h10;
            4'hA: seg_decode = 7'h08;
            4'hB: seg_decode = 7'h03;
            4'hC: seg_decode = 7'h46;
            4'hD: seg_decode = 7'h21;
            4'hE: seg_decode = 7'h06;
            default: seg_decode = 7'h0E;
        endcase
    endfunction

    // Register file: per-digit writes, VALUE broadcast of nibbles, CTRL.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                dig_nib[i]   <= 4'h0;
                dig_blank[i] <= 1'b1;
                dig_blink[i] <= 1'b0;
                dig_raw[i]   <= 7'h7F;
            end
            ctrl_en     <= 1'b1;
            ctrl_raw    <= 1'b0;
            ctrl_bright <= '1;
        end else if (avs_write) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (avs_address == 4'(i)) begin
                    dig_nib[i]   <= avs_writedata[3:0];
                    dig_blank[i] <= avs_writedata[4];
                    dig_blink[i] <= avs_writedata[5];
                    dig_raw[i]   <= avs_writedata[14:8];
                end
                if (avs_address == ADDR_VALUE) begin
                    dig_nib[i]   <= avs_writedata[4*i +: 4];
                    dig_blank[i] <= 1'b0;
                end
            end
            if (avs_address == ADDR_CTRL) begin
                ctrl_en     <= avs_writedata[0];
                ctrl_raw    <= avs_writedata[1];
                ctrl_bright <= avs_writedata[4 +: PWM_BITS];
            end
        end
    end

    // Free-running blink and PWM timers; only reset restarts them.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            wrap_cnt    <= 16'h0000;
            pwm_cnt     <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
                wrap_cnt    <= wrap_cnt + 16'd1;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    assign pwm_on = (pwm_cnt <= ctrl_bright);

    // Read mux: digit, CTRL and STATUS fields; everything else reads zero.
    always_comb begin
        rd_next = 32'h0;
        case (avs_address)
            ADDR_CTRL: begin
                rd_next[0]              = ctrl_en;
                rd_next[1]              = ctrl_raw;
                rd_next[4 +: PWM_BITS]  = ctrl_bright;
            end
            ADDR_STATUS: begin
                rd_next[0]     = blink_phase;
                rd_next[31:16] = wrap_cnt;
            end
            default: ;
        endcase
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (avs_address == 4'(i)) begin
                rd_next = {17'd0, dig_raw[i], 2'b00, dig_blink[i], dig_blank[i], dig_nib[i]};
            end
        end
    end

    // Read data register: captured on a read strobe, held otherwise.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            avs_readdata <= 32'h0;
        end else if (avs_read) begin
            avs_readdata <= rd_next;
        end
    end

    // Segment selection: source pattern unless any blanking condition applies.
    always_comb begin
        hex_next = '1;
        src      = 7'h7F;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            src = ctrl_raw ? dig_raw[i] : seg_decode(dig_nib[i]);
            if (ctrl_en && !dig_blank[i] && !(dig_blink[i] && blink_phase) && pwm_on) begin
                hex_next[7*i +: 7] = src;
            end
        end
    end

    // Registered segment outputs, all segments off in reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hex_out <= '1;
        end else begin
            hex_out <= hex_next;
        end
    end

endmodule

// File: tb/tb_sevseg_avalon_ctrl.sv
// Self-checking bench for sevseg_avalon_ctrl with a short blink period.
module tb_sevseg_avalon_ctrl;

  localparam int ND = 6;
  localparam int BH = 4;

  logic        clk;
  logic        reset_n;
  logic [3:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic [7*ND-1:0] hex_out;

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;  // clock edges since the last reset edge

  // reference model state
  logic [3:0] m_nib   [ND];
  logic       m_blank [ND];
  logic       m_blink [ND];
  logic [6:0] m_raw   [ND];
  logic       m_en;
  logic       m_rawmode;
  logic [3:0] m_bright;
  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  sevseg_avalon_ctrl #(.NUM_DIGITS(ND), .BLINK_HALF(BH), .PWM_BITS(4)) dut (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_read(avs_read), .avs_readdata(avs_readdata),
    .hex_out(hex_out)
  );

  // clock / reset bookkeeping
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) k <= reset_n ? k + 1 : 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic void model_reset();
    for (int i = 0; i < ND; i++) begin
      m_nib[i] = 4'h0; m_blank[i] = 1'b1; m_blink[i] = 1'b0; m_raw[i] = 7'h7F;
    end
    m_en = 1'b1; m_rawmode = 1'b0; m_bright = 4'hF;
  endfunction

  function automatic void model_write(logic [3:0] a, logic [31:0] d);
    if (a < ND) begin
      m_nib[a] = d[3:0]; m_blank[a] = d[4]; m_blink[a] = d[5]; m_raw[a] = d[14:8];
    end else if (a == 4'h6) begin
      m_en = d[0]; m_rawmode = d[1]; m_bright = d[7:4];
    end else if (a == 4'h7) begin
      for (int i = 0; i < ND; i++) begin
        m_nib[i] = 4'((d >> (4 * i)) & 32'hF);
        m_blank[i] = 1'b0;
      end
    end
  endfunction

  // c = clock edges elapsed since reset before the edge that samples the model
  function automatic logic [31:0] exp_read(logic [3:0] a, int c);
    logic [31:0] r;
    r = 32'h0;
    if (a < ND) r = {17'd0, m_raw[a], 2'b00, m_blink[a], m_blank[a], m_nib[a]};
    else if (a == 4'h6) r = {24'd0, m_bright, 2'b00, m_rawmode, m_en};
    else if (a == 4'h8) r = {16'((c / BH) % 65536), 15'd0, 1'((c / BH) % 2)};
    return r;
  endfunction

  function automatic logic [7*ND-1:0] exp_hex(int c);
    logic [7*ND-1:0] r;
    logic [6:0] src;
    int phase, pwm;
    phase = (c / BH) % 2;
    pwm = c % 16;
    r = '1;
    for (int i = 0; i < ND; i++) begin
      src = m_rawmode ? m_raw[i] : dec_tab[m_nib[i]];
      if (m_en && !m_blank[i] && !(m_blink[i] && phase == 1) && pwm <= int'(m_bright))
        r[7*i +: 7] = src;
    end
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    tick();
    avs_write = 1'b0;
    model_write(a, d);
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] rd);
    avs_address = a; avs_read = 1'b1;
    tick();
    avs_read = 1'b0;
    rd = avs_readdata;
  endtask

  task automatic bus_rw(input logic [3:0] a, input logic [31:0] d, output logic [31:0] rd);
    avs_address = a; avs_writedata = d; avs_write = 1'b1; avs_read = 1'b1;
    tick();
    avs_write = 1'b0; avs_read = 1'b0;
    rd = avs_readdata;
    model_write(a, d);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] rd;
    reset_n = 1'b0;
    tick(); tick();
    n_cmp++;
    if (hex_out !== '1) begin n_bad++; $display("FAIL reset_hex: got %h required %h", hex_out, {7*ND{1'b1}}); end
    n_cmp++;
    if (avs_readdata !== 32'h0) begin n_bad++; $display("FAIL reset_readdata: got %h required 0", avs_readdata); end
    reset_n = 1'b1;
    model_reset();
    bus_read(4'h6, rd);
    n_cmp++;
    if (rd !== 32'h0000_00F1) begin n_bad++; $display("FAIL reset_ctrl: got %h required 000000f1", rd); end
    for (int i = 0; i < ND; i++) begin
      bus_read(4'(i), rd);
      n_cmp++;
      if (rd !== 32'h0000_7F10) begin n_bad++; $display("FAIL reset_digit%0d: got %h required 00007f10", i, rd); end
    end
    n_cmp++;
    if (hex_out !== '1) begin n_bad++; $display("FAIL reset_hex_idle: got %h required all ones", hex_out); end
  endtask

  task automatic test_value();
    logic [31:0] rd, v, e;
    int i;
    bus_write(4'h7, 32'h0012_3456);
    tick();
    n_cmp++;
    if (hex_out !== exp_hex(k - 1)) begin n_bad++; $display("FAIL value_hex: got %h required %h", hex_out, exp_hex(k - 1)); end
    bus_read(4'h0, rd);
    n_cmp++;
    if (rd !== 32'h0000_7F06) begin n_bad++; $display("FAIL value_digit0: got %h required 00007f06", rd); end
    repeat (4) begin
      v = $urandom;
      bus_write(4'h7, v);
      tick();
      n_cmp++;
      if (hex_out !== exp_hex(k - 1)) begin n_bad++; $display("FAIL value_rand_hex: got %h required %h", hex_out, exp_hex(k - 1)); end
      i = $urandom_range(0, ND - 1);
      e = exp_read(4'(i), k);
      bus_read(4'(i), rd);
      n_cmp++;
      if (rd !== e) begin n_bad++; $display("FAIL value_rand_digit%0d: got %h required %h", i, rd, e); end
    end
  endtask

  task automatic test_latency();
    logic [7*ND-1:0] old_hex;
    logic [31:0] d;
    bus_write(4'h6, 32'h0000_00F1);
    d = $urandom & 32'hFFFF_FFC0;
    d[3:0] = 4'(m_nib[0] + 4'h5);
    old_hex = exp_hex(k);
    bus_write(4'h0, d);
    n_cmp++;
    if (hex_out !== old_hex) begin n_bad++; $display("FAIL latency_write_edge: got %h required %h", hex_out, old_hex); end
    tick();
    n_cmp++;
    if (hex_out !== exp_hex(k - 1)) begin n_bad++; $display("FAIL latency_next_edge: got %h required %h", hex_out, exp_hex(k - 1)); end
  endtask

  task automatic test_random();
    logic [31:0] rd, d, e;
    int i;
    repeat (3) begin
      repeat (6) begin
        i = $urandom_range(0, ND - 1);
        d = $urandom;
        bus_write(4'(i), d);
        e = exp_read(4'(i), k);
        bus_read(4'(i), rd);
        n_cmp++;
        if (rd !== e) begin n_bad++; $display("FAIL rand_digit%0d: got %h required %h", i, rd, e); end
      end
      d = $urandom;
      d[0] = ($urandom_range(0, 3) != 0);
      bus_write(4'h6, d);
      e = exp_read(4'h6, k);
      bus_read(4'h6, rd);
      n_cmp++;
      if (rd !== e) begin n_bad++; $display("FAIL rand_ctrl: got %h required %h", rd, e); end
      repeat (20) begin
        tick();
        n_cmp++;
        if (hex_out !== exp_hex(k - 1)) begin n_bad++; $display("FAIL rand_hex: got %h required %h", hex_out, exp_hex(k - 1)); end
      end
    end
  endtask

  task automatic test_pwm();
    int on_cnt;
    bus_write(4'h2, 32'h0000_5500);
    bus_write(4'h6, 32'h0000_0003);
    on_cnt = 0;
    repeat (32) begin
      tick();
      n_cmp++;
      if (hex_out !== exp_hex(k - 1)) begin n_bad++; $display("FAIL pwm_hex: got %h required %h", hex_out, exp_hex(k - 1)); end
      if (hex_out[20:14] == 7'h55) on_cnt++;
    end
    n_cmp++;
    if (on_cnt != 2) begin n_bad++; $display("FAIL pwm_duty: got %0d on cycles required 2 of 32", on_cnt); end
  endtask

  task automatic test_blink();
    logic [31:0] rd, e;
    int on_cnt;
    bus_write(4'h6, 32'h0000_00F1);
    bus_write(4'h1, 32'h0000_7F28);
    tick();
    on_cnt = 0;
    repeat (24) begin
      tick();
      n_cmp++;
      if (hex_out !== exp_hex(k - 1)) begin n_bad++; $display("FAIL blink_hex: got %h required %h", hex_out, exp_hex(k - 1)); end
      if (hex_out[13:7] == 7'h00) on_cnt++;
    end
    n_cmp++;
    if (on_cnt != 12) begin n_bad++; $display("FAIL blink_duty: got %0d on cycles required 12 of 24", on_cnt); end
    repeat (3) begin
      e = exp_read(4'h8, k);
      bus_read(4'h8, rd);
      n_cmp++;
      if (rd !== e) begin n_bad++; $display("FAIL blink_status: got %h required %h", rd, e); end
      repeat ($urandom_range(1, 6)) tick();
    end
  endtask

  task automatic test_rw();
    logic [31:0] rd, e, d;
    e = exp_read(4'h3, k);
    d = $urandom;
    bus_rw(4'h3, d, rd);
    n_cmp++;
    if (rd !== e) begin n_bad++; $display("FAIL rw_old_value: got %h required %h", rd, e); end
    e = exp_read(4'h3, k);
    bus_read(4'h3, rd);
    n_cmp++;
    if (rd !== e) begin n_bad++; $display("FAIL rw_new_value: got %h required %h", rd, e); end
    bus_write(4'h6, 32'hFFFF_FF05);
    repeat (3) tick();
    n_cmp++;
    if (avs_readdata !== e) begin n_bad++; $display("FAIL rw_hold: got %h required %h", avs_readdata, e); end
    bus_read(4'hC, rd);
    n_cmp++;
    if (rd !== 32'h0) begin n_bad++; $display("FAIL rw_unmapped_read: got %h required 0", rd); end
    bus_read(4'h7, rd);
    n_cmp++;
    if (rd !== 32'h0) begin n_bad++; $display("FAIL rw_value_read: got %h required 0", rd); end
    bus_write(4'hA, 32'hFFFF_FFFF);
    for (int i = 0; i <= 6; i++) begin
      e = exp_read(4'(i), k);
      bus_read(4'(i), rd);
      n_cmp++;
      if (rd !== e) begin n_bad++; $display("FAIL rw_after_unmapped_%0d: got %h required %h", i, rd, e); end
    end
  endtask

  task automatic test_value_wrap();
    logic [31:0] rd, e;
    int guard;
    guard = 0;
    while ((k % BH) != (BH - 1) && guard < 2 * BH) begin tick(); guard++; end
    bus_write(4'h7, $urandom);
    e = exp_read(4'h8, k);
    bus_read(4'h8, rd);
    n_cmp++;
    if (rd !== e) begin n_bad++; $display("FAIL wrap_status: got %h required %h", rd, e); end
    for (int i = 0; i < ND; i++) begin
      e = exp_read(4'(i), k);
      bus_read(4'(i), rd);
      n_cmp++;
      if (rd !== e) begin n_bad++; $display("FAIL wrap_digit%0d: got %h required %h", i, rd, e); end
    end
    tick();
    n_cmp++;
    if (hex_out !== exp_hex(k - 1)) begin n_bad++; $display("FAIL wrap_hex: got %h required %h", hex_out, exp_hex(k - 1)); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    bus_read(4'h6, rd);
    repeat ($urandom_range(1, 5)) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    model_reset();
    n_cmp++;
    if (hex_out !== '1) begin n_bad++; $display("FAIL mid_reset_hex: got %h required all ones", hex_out); end
    n_cmp++;
    if (avs_readdata !== 32'h0) begin n_bad++; $display("FAIL mid_reset_readdata: got %h required 0", avs_readdata); end
    bus_read(4'h8, rd);
    n_cmp++;
    if (rd !== 32'h0) begin n_bad++; $display("FAIL mid_reset_status: got %h required 0", rd); end
    bus_read(4'h6, rd);
    n_cmp++;
    if (rd !== 32'h0000_00F1) begin n_bad++; $display("FAIL mid_reset_ctrl: got %h required 000000f1", rd); end
    for (int i = 0; i < ND; i++) begin
      bus_read(4'(i), rd);
      n_cmp++;
      if (rd !== 32'h0000_7F10) begin n_bad++; $display("FAIL mid_reset_digit%0d: got %h required 00007f10", i, rd); end
    end
    bus_write(4'h7, 32'h00AB_CDEF);
    repeat (20) begin
      tick();
      n_cmp++;
      if (hex_out !== exp_hex(k - 1)) begin n_bad++; $display("FAIL mid_reset_hex_run: got %h required %h", hex_out, exp_hex(k - 1)); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    avs_address = 4'h0;
    avs_write = 1'b0;
    avs_writedata = 32'h0;
    avs_read = 1'b0;
    model_reset();
    test_reset();
    test_value();
    test_latency();
    test_random();
    test_pwm();
    test_blink();
    test_rw();
    test_value_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
